// File: rtl/stepper_step_ctrl.sv
// Purpose : step/dir sequencer for one stepper axis, one step per enable_step tick toward a signed target.
// Latency : dir_out/busy one cycle after command accept; step_out rises one cycle after an accepted tick.
// Backpressure: cmd_ready is high only in IDLE, so a held cmd_valid waits until the running move ends.
// Ports:
//   clk_100mhz, rst       - system clock, synchronous active-high reset
//   enable_step           - 1-cycle step tick from the PWM generator
//   cmd_valid/cmd_target  - absolute signed target command; cmd_ready = accepting
//   abort                 - stop the move, letting an in-flight pulse finish first
//   step_out, dir_out     - driver pins (dir_out 1 = increasing position)
//   busy, position        - move in progress, signed step count issued so far
//   done, aborted         - 1-cycle completion pulses, mutually exclusive
module stepper_step_ctrl #(
  parameter int POS_W            = 16,
  parameter int PULSE_CYCLES     = 100,
  parameter int DIR_SETUP_CYCLES = 50
) (
  input  logic                    clk_100mhz,
  input  logic                    rst,
  input  logic                    enable_step,
  input  logic                    cmd_valid,
  input  logic signed [POS_W-1:0] cmd_target,
  output logic                    cmd_ready,
  input  logic                    abort,
  output logic                    step_out,
  output logic                    dir_out,
  output logic                    busy,
  output logic signed [POS_W-1:0] position,
  output logic                    done,
  output logic                    aborted
);

  localparam int CNT_MAX = (PULSE_CYCLES > DIR_SETUP_CYCLES) ? PULSE_CYCLES : DIR_SETUP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIR_SETUP,
    S_WAIT_TICK,
    S_PULSE
  } state_t;

  state_t                   state, state_n;
  logic [CNT_W-1:0]         cnt, cnt_n;
  logic signed [POS_W-1:0]  target, target_n;
  logic signed [POS_W-1:0]  pos_n;
  logic                     dir_n, step_n, done_n, aborted_n;
  logic                     abort_pend, abort_pend_n;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    target_n     = target;
    pos_n        = position;
    dir_n        = dir_out;
    step_n       = step_out;
    done_n       = 1'b0;
    aborted_n    = 1'b0;
    abort_pend_n = abort_pend;

    case (state)
      S_IDLE: begin
        abort_pend_n = 1'b0;
        if (cmd_valid) begin
          target_n = cmd_target;
          if (cmd_target == position) begin
            // Already there: report completion without touching the pins.
            done_n = 1'b1;
          end else begin
            dir_n   = (cmd_target > position);
            state_n = S_DIR_SETUP;
            cnt_n   = '0;
          end
        end
      end

      S_DIR_SETUP: begin
        if (abort) begin
          state_n   = S_IDLE;
          aborted_n = 1'b1;
        end else if (cnt == SETUP_LAST) begin
          state_n = S_WAIT_TICK;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_WAIT_TICK: begin
        if (abort) begin
          state_n   = S_IDLE;
          aborted_n = 1'b1;
        end else if (enable_step) begin
          // Position counts steps issued, so it moves with the rising edge.
          state_n = S_PULSE;
          step_n  = 1'b1;
          cnt_n   = '0;
          pos_n   = dir_out ? position + POS_W'(1) : position - POS_W'(1);
        end
      end

      S_PULSE: begin
        // Abort during a pulse is remembered so the pulse always runs full width.
        if (abort) abort_pend_n = 1'b1;
        if (cnt == PULSE_LAST) begin
          step_n       = 1'b0;
          abort_pend_n = 1'b0;
          if (position == target) begin
            // Reaching the target wins over a coincident abort.
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else if (abort_pend || abort) begin
            state_n   = S_IDLE;
            aborted_n = 1'b1;
          end else begin
            state_n = S_WAIT_TICK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
        step_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      target     <= '0;
      position   <= '0;
      dir_out    <= 1'b0;
      step_out   <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      abort_pend <= 1'b0;
      busy       <= 1'b0;
      cmd_ready  <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      target     <= target_n;
      position   <= pos_n;
      dir_out    <= dir_n;
      step_out   <= step_n;
      done       <= done_n;
      aborted    <= aborted_n;
      abort_pend <= abort_pend_n;
      // Registered copies of the state decode so they align with the state register.
      busy       <= (state_n != S_IDLE);
      cmd_ready  <= (state_n == S_IDLE);
    end
  end

endmodule

// File: tb/tb_stepper_step_ctrl.sv
// Bench for stepper_step_ctrl: directed moves checked against a countdown-based
// reference model every cycle, plus hand-computed end-of-scenario expectations.
module tb_stepper_step_ctrl;
  localparam int PW = 100;
  localparam int DS = 50;

  logic               clk_100mhz = 1'b0;
  logic               rst = 1'b1;
  logic               enable_step = 1'b0;
  logic               cmd_valid = 1'b0;
  logic signed [15:0] cmd_target = '0;
  logic               abort = 1'b0;
  logic               cmd_ready, step_out, dir_out, busy, done, aborted;
  logic signed [15:0] position;

  always #5 clk_100mhz = ~clk_100mhz;

  stepper_step_ctrl #(.POS_W(16), .PULSE_CYCLES(PW), .DIR_SETUP_CYCLES(DS)) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .enable_step(enable_step),
    .cmd_valid  (cmd_valid),
    .cmd_target (cmd_target),
    .cmd_ready  (cmd_ready),
    .abort      (abort),
    .step_out   (step_out),
    .dir_out    (dir_out),
    .busy       (busy),
    .position   (position),
    .done       (done),
    .aborted    (aborted)
  );

  // ---------------- reference model (integer bookkeeping of a move) ----------------
  bit m_valid = 0, m_in = 0, m_dir = 0, m_step = 0, m_done = 0, m_aborted = 0, m_abseen = 0;
  int m_pos = 0, m_tgt = 0, m_setup = 0, m_pulse = 0;

  always @(posedge clk_100mhz) begin
    m_done    = 0;
    m_aborted = 0;
    if (rst) begin
      m_valid = 1; m_in = 0; m_pos = 0; m_tgt = 0; m_dir = 0;
      m_setup = 0; m_pulse = 0; m_abseen = 0; m_step = 0;
    end else if (m_valid) begin
      if (!m_in) begin
        if (cmd_valid) begin
          if (int'(cmd_target) == m_pos) m_done = 1;
          else begin
            m_in = 1; m_tgt = int'(cmd_target); m_dir = (m_tgt > m_pos);
            m_setup = DS; m_abseen = 0;
          end
        end
      end else if (m_setup > 0) begin
        if (abort) begin m_in = 0; m_aborted = 1; m_setup = 0; end
        else m_setup--;
      end else if (m_pulse > 0) begin
        if (abort) m_abseen = 1;
        m_pulse--;
        if (m_pulse == 0) begin
          m_step = 0;
          if (m_pos == m_tgt) begin m_in = 0; m_done = 1; end
          else if (m_abseen) begin m_in = 0; m_aborted = 1; end
        end
      end else begin
        if (abort) begin m_in = 0; m_aborted = 1; end
        else if (enable_step) begin
          m_step = 1; m_pos += m_dir ? 1 : -1; m_pulse = PW;
        end
      end
    end
  end

  // ---------------- per-cycle compare + event monitor ----------------
  int cyc_tests = 0, cyc_fails = 0;
  int cyc = 0, rise_cnt = 0, done_cnt = 0, abort_cnt = 0, busy_cyc = 0, width_bad = 0;
  int run_len = 0, dir_chg_cyc = -1, last_rise_cyc = -1, gap_first = -1;
  bit prev_step = 0, prev_dir = 0;

  always @(negedge clk_100mhz) begin
    cyc++;
    if (m_valid) begin
      cyc_tests++;
      if (step_out !== m_step || dir_out !== m_dir || busy !== m_in || cmd_ready !== !m_in ||
          int'(position) != m_pos || done !== m_done || aborted !== m_aborted) begin
        cyc_fails++;
        if (cyc_fails <= 20)
          $display("FAIL cycle_model cyc=%0d got step=%b dir=%b busy=%b rdy=%b pos=%0d done=%b ab=%b want step=%b dir=%b busy=%b rdy=%b pos=%0d done=%b ab=%b",
                   cyc, step_out, dir_out, busy, cmd_ready, position, done, aborted,
                   m_step, m_dir, m_in, !m_in, m_pos, m_done, m_aborted);
      end
      if (dir_out != prev_dir) dir_chg_cyc = cyc;
      if (step_out === 1'b1 && !prev_step) begin
        rise_cnt++;
        if (dir_chg_cyc > last_rise_cyc) gap_first = cyc - dir_chg_cyc;
        last_rise_cyc = cyc;
      end
      if (step_out === 1'b1) run_len++;
      else if (prev_step) begin
        if (run_len != PW) width_bad++;
        run_len = 0;
      end
      if (done === 1'b1) done_cnt++;
      if (aborted === 1'b1) abort_cnt++;
      if (busy === 1'b1) busy_cyc++;
      prev_step = (step_out === 1'b1);
      prev_dir  = (dir_out === 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  int lit_tests = 0, lit_fails = 0;
  int tick_ph = 0;

  task automatic check(input string name, input int act, input int exp);
    lit_tests++;
    if (act != exp) begin
      lit_fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step1(input int period);
    @(posedge clk_100mhz);
    #1;
    tick_ph++;
    enable_step = (period > 0) && (tick_ph % period == 0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step1(0);
  endtask

  task automatic send_cmd(input int t);
    cmd_target = 16'(t);
    cmd_valid  = 1'b1;
    @(posedge clk_100mhz);
    #1;
    cmd_valid   = 1'b0;
    enable_step = 1'b0;
  endtask

  task automatic run_move(input string name, input int period, input int budget);
    int base;
    bit ended;
    base  = done_cnt + abort_cnt;
    ended = 0;
    tick_ph = 0;
    for (int i = 0; i < budget && !ended; i++) begin
      step1(period);
      @(negedge clk_100mhz);
      #1;
      if (done_cnt + abort_cnt > base) ended = 1;
    end
    enable_step = 1'b0;
    check({name, "_end_seen"}, int'(ended), 1);
  endtask

  int r0, d0, a0, b0, w0;
  bit found;

  initial begin
    // Reset
    repeat (3) @(posedge clk_100mhz);
    #1 rst = 1'b0;
    @(negedge clk_100mhz);
    check("rst_step", int'(step_out), 0);
    check("rst_dir", int'(dir_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pos", int'(position), 0);
    check("rst_done", int'(done), 0);
    check("rst_aborted", int'(aborted), 0);
    check("rst_ready", int'(cmd_ready), 1);

    // Target equals position: done at T+1, no motion
    #1; r0 = rise_cnt; d0 = done_cnt; b0 = busy_cyc;
    send_cmd(0);
    @(negedge clk_100mhz);
    check("zero_done_t1", int'(done), 1);
    idle_cycles(5);
    @(negedge clk_100mhz); #1;
    check("zero_done_once", done_cnt - d0, 1);
    check("zero_busy_never", busy_cyc - b0, 0);
    check("zero_no_step", rise_cnt - r0, 0);

    // 0 -> +3, ticks every 1000 cycles
    r0 = rise_cnt; d0 = done_cnt; a0 = abort_cnt; w0 = width_bad;
    send_cmd(3);
    run_move("fwd3", 1000, 5000);
    idle_cycles(2);
    @(negedge clk_100mhz); #1;
    check("fwd3_pos", int'(position), 3);
    check("fwd3_pulses", rise_cnt - r0, 3);
    check("fwd3_done", done_cnt - d0, 1);
    check("fwd3_aborted", abort_cnt - a0, 0);
    check("fwd3_width", width_bad - w0, 0);
    check("fwd3_dir", int'(dir_out), 1);
    check("fwd3_busy", int'(busy), 0);

    // +3 -> -2: direction set up before first step
    r0 = rise_cnt; d0 = done_cnt;
    send_cmd(-2);
    run_move("rev5", 200, 3000);
    @(negedge clk_100mhz); #1;
    check("rev5_pos", int'(position), -2);
    check("rev5_pulses", rise_cnt - r0, 5);
    check("rev5_done", done_cnt - d0, 1);
    check("rev5_dir", int'(dir_out), 0);
    check("rev5_dir_setup_ge50", int'(gap_first >= DS), 1);

    // Ticks during DIR_SETUP and during a pulse are ignored
    r0 = rise_cnt; d0 = done_cnt;
    send_cmd(0);
    idle_cycles(10);
    step1(1);                 // tick sampled in DIR_SETUP
    idle_cycles(43);
    @(negedge clk_100mhz); #1;
    check("setup_tick_ignored", rise_cnt - r0, 0);
    check("setup_pos_hold", int'(position), -2);
    step1(1);                 // tick sampled in WAIT_TICK
    idle_cycles(30);
    step1(1);                 // tick sampled mid-pulse
    idle_cycles(100);
    @(negedge clk_100mhz); #1;
    check("pulse_tick_ignored", rise_cnt - r0, 1);
    check("pulse_tick_pos", int'(position), -1);
    run_move("fwd2", 200, 2000);
    @(negedge clk_100mhz); #1;
    check("fwd2_pos", int'(position), 0);
    check("fwd2_pulses", rise_cnt - r0, 2);
    check("fwd2_done", done_cnt - d0, 1);

    // 1-cycle abort 20 cycles into pulse 2 of a +5 move
    r0 = rise_cnt; d0 = done_cnt; a0 = abort_cnt; w0 = width_bad;
    send_cmd(5);
    found = 0;
    tick_ph = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step1(300);
      @(negedge clk_100mhz); #1;
      if (rise_cnt - r0 >= 2) found = 1;
    end
    check("abort_wait_pulse2", int'(found), 1);
    idle_cycles(19);
    @(negedge clk_100mhz); #1;
    abort = 1'b1;
    step1(0);
    abort = 1'b0;
    run_move("abort", 300, 3000);
    idle_cycles(2);
    @(negedge clk_100mhz); #1;
    check("abort_pos", int'(position), 2);
    check("abort_once", abort_cnt - a0, 1);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_pulses", rise_cnt - r0, 2);
    check("abort_full_width", width_bad - w0, 0);
    check("abort_busy", int'(busy), 0);

    // Reset in the middle of a pulse
    send_cmd(5);
    found = 0;
    tick_ph = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step1(150);
      @(negedge clk_100mhz);
      if (step_out === 1'b1) found = 1;
    end
    check("rst_wait_pulse", int'(found), 1);
    idle_cycles(10);
    @(negedge clk_100mhz);
    rst = 1'b1;
    @(posedge clk_100mhz);
    #1 rst = 1'b0;
    @(negedge clk_100mhz);
    check("midrst_step", int'(step_out), 0);
    check("midrst_pos", int'(position), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(cmd_ready), 1);
    #1; d0 = done_cnt;
    send_cmd(1);
    run_move("after_rst", 150, 2000);
    @(negedge clk_100mhz); #1;
    check("after_rst_pos", int'(position), 1);
    check("after_rst_done", done_cnt - d0, 1);

    idle_cycles(3);
    @(negedge clk_100mhz); #1;
    $display("[TB] %0d tests run, %0d failed", cyc_tests + lit_tests, cyc_fails + lit_fails);
    $finish;
  end

endmodule
